// File: rtl/bridge_multi.sv
// bridge_multi: registered CPU-to-device bridge for NUM_DEV equal-stride
// memory-mapped slots. Provides a req/ready handshake with device wait
// states, an access timeout, an error response for rejected accesses and
// synchronised interrupt collection into HWInt[7:2].
module bridge_multi #(
    parameter int unsigned NUM_DEV      = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h7f00,
    parameter logic [31:0] STRIDE       = 32'h10,
    parameter int unsigned WINDOW_BYTES = 12,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_req,
    input  logic [31:0]               cpu_address,
    input  logic [31:0]               cpu_write_data,
    input  logic [2:0]                cpu_write_size,
    input  logic [2:0]                cpu_read_size,
    output logic                      cpu_ready,
    output logic                      cpu_error,
    output logic [31:0]               cpu_read_data,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic [3:0]                dev_address,
    output logic [31:0]               dev_write_data,
    output logic                      dev_write_enable,
    input  logic [32*NUM_DEV-1:0]     dev_read_data,
    input  logic [NUM_DEV-1:0]        dev_ready,
    input  logic [NUM_DEV-1:0]        dev_irq,
    input  logic                      outer_interruption,
    output logic [5:0]                interrupt_request
);

    localparam int unsigned SLOT_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // FSM state and per-access context
    state_t              state_r;
    state_t              state_n_s;
    logic [SLOT_W-1:0]   slot_r;
    logic [SLOT_W-1:0]   slot_n_s;
    logic                write_r;
    logic                write_n_s;
    logic [7:0]          count_r;
    logic [7:0]          count_n_s;

    // Response generation
    logic                respond_s;
    logic                resp_err_s;
    logic [31:0]         resp_data_s;

    // Registered outputs
    logic                cpu_ready_r;
    logic                cpu_error_r;
    logic [31:0]         cpu_read_data_r;
    logic [NUM_DEV-1:0]  dev_sel_r;
    logic [NUM_DEV-1:0]  dev_sel_n_s;
    logic                dev_we_r;

    // Accept checks
    logic                addr_hit_s;
    logic [SLOT_W-1:0]   addr_slot_s;
    logic                instr_ok_s;
    logic                accept_s;

    // Selected-slot view of the device bus
    logic [31:0]         sel_word_s;
    logic                sel_ready_s;

    // Interrupt synchronisers
    logic                outer_meta_r;
    logic                outer_sync_r;
    logic [NUM_DEV-1:0]  dev_irq_r;
    logic [5:0]          irq_bus_s;

    // Address path to the devices is a straight pass-through of the CPU inputs
    assign dev_address    = cpu_address[3:0];
    assign dev_write_data = cpu_write_data;

    // Only full-word stores, or full-word loads that are not also stores, are accepted
    assign instr_ok_s = (cpu_write_size == 3'd4) ||
                        ((cpu_write_size == 3'd0) && (cpu_read_size == 3'd4));

    // Find which slot window (if any) contains the requested address
    always_comb begin : addr_decode
        logic [32:0] lo_v;
        logic [32:0] hi_v;
        lo_v        = 33'd0;
        hi_v        = 33'd0;
        addr_hit_s  = 1'b0;
        addr_slot_s = {SLOT_W{1'b0}};
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            lo_v = {1'b0, BASE_ADDR} + (33'(i) * {1'b0, STRIDE});
            hi_v = lo_v + 33'(WINDOW_BYTES);
            if (!addr_hit_s && ({1'b0, cpu_address} >= lo_v) && ({1'b0, cpu_address} < hi_v)) begin
                addr_hit_s  = 1'b1;
                addr_slot_s = SLOT_W'(i);
            end else begin
                addr_hit_s  = addr_hit_s;
            end
        end
    end

    assign accept_s = instr_ok_s && addr_hit_s && (cpu_address[1:0] == 2'b00);

    // Pick the read word and ready flag of the latched slot; other slots are ignored
    always_comb begin
        sel_word_s  = 32'd0;
        sel_ready_s = 1'b0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (slot_r == SLOT_W'(i)) begin
                sel_word_s  = dev_read_data[32*i +: 32];
                sel_ready_s = dev_ready[i];
            end else begin
                sel_word_s  = sel_word_s;
            end
        end
    end

    // Next-state logic and response value for the three-state access FSM
    always_comb begin
        state_n_s   = state_r;
        slot_n_s    = slot_r;
        write_n_s   = write_r;
        count_n_s   = count_r;
        respond_s   = 1'b0;
        resp_err_s  = 1'b0;
        resp_data_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (accept_s) begin
                        state_n_s = ST_ACCESS;
                        slot_n_s  = addr_slot_s;
                        write_n_s = (cpu_write_size == 3'd4);
                        count_n_s = 8'd0;
                    end else begin
                        // Rejected accesses never touch the device bus
                        state_n_s  = ST_RESPOND;
                        respond_s  = 1'b1;
                        resp_err_s = 1'b1;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A ready arriving on the terminal-count cycle still counts as success
                if (sel_ready_s) begin
                    state_n_s   = ST_RESPOND;
                    respond_s   = 1'b1;
                    resp_err_s  = 1'b0;
                    resp_data_s = write_r ? 32'd0 : sel_word_s;
                end else if (count_r == 8'(TIMEOUT - 1)) begin
                    state_n_s  = ST_RESPOND;
                    respond_s  = 1'b1;
                    resp_err_s = 1'b1;
                end else begin
                    count_n_s = count_r + 8'd1;
                end
            end
            ST_RESPOND: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // One-hot slot select for the cycle after this edge, driven only in ACCESS
    always_comb begin
        dev_sel_n_s = {NUM_DEV{1'b0}};
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if ((state_n_s == ST_ACCESS) && (slot_n_s == SLOT_W'(i))) begin
                dev_sel_n_s[i] = 1'b1;
            end else begin
                dev_sel_n_s[i] = 1'b0;
            end
        end
    end

    // FSM state and access context registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            slot_r  <= {SLOT_W{1'b0}};
            write_r <= 1'b0;
            count_r <= 8'd0;
        end else begin
            state_r <= state_n_s;
            slot_r  <= slot_n_s;
            write_r <= write_n_s;
            count_r <= count_n_s;
        end
    end

    // Output registers track the next state so they line up with it exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ready_r     <= 1'b0;
            cpu_error_r     <= 1'b0;
            cpu_read_data_r <= 32'd0;
            dev_sel_r       <= {NUM_DEV{1'b0}};
            dev_we_r        <= 1'b0;
        end else begin
            cpu_ready_r <= respond_s;
            cpu_error_r <= respond_s & resp_err_s;
            if (respond_s) begin
                cpu_read_data_r <= resp_data_s;
            end else begin
                cpu_read_data_r <= cpu_read_data_r;
            end
            dev_sel_r <= dev_sel_n_s;
            dev_we_r  <= (state_n_s == ST_ACCESS) && write_n_s;
        end
    end

    // Interrupt inputs: two flops for the asynchronous outer line, one for device levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outer_meta_r <= 1'b0;
            outer_sync_r <= 1'b0;
            dev_irq_r    <= {NUM_DEV{1'b0}};
        end else begin
            outer_meta_r <= outer_interruption;
            outer_sync_r <= outer_meta_r;
            dev_irq_r    <= dev_irq;
        end
    end

    // Pack device levels at the bottom and the outer interrupt just above them
    always_comb begin
        irq_bus_s              = 6'd0;
        irq_bus_s[NUM_DEV-1:0] = dev_irq_r;
        irq_bus_s[NUM_DEV]     = outer_sync_r;
    end

    assign cpu_ready         = cpu_ready_r;
    assign cpu_error         = cpu_error_r;
    assign cpu_read_data     = cpu_read_data_r;
    assign dev_sel           = dev_sel_r;
    assign dev_write_enable  = dev_we_r;
    assign interrupt_request = irq_bus_s;

endmodule
